alu_reservation_station: RTL
============================

// Module: alu_reservation_station
// PURPOSE
//  Parametrised reservation station for the data-processing (ALU) path of the Tomasulo core.
//  Sits between issue/rename (register-result-status lookup, ROB tail) and the ALU.
//  Holds DEPTH instructions and wakes waiting operands from the CDB, including in the append cycle.
//  Issues ready entries through a valid/ready handshake; an entry is freed at issue, not at writeback.
// PARAMETERS
//  DEPTH   4   number of station entries (>=2)
//  TAG_W   3   ROB index width; CDB/rename tags are TAG_W bits
//  DATA_W  32  operand/result width
// PORTS
//  CLK          in   1       clock, all state updates on posedge
//  Reset_n      in   1       synchronous reset, active-low
//  Flush        in   1       synchronous squash of all entries and the output register
//  In_Valid     in   1       issue stage presents an instruction
//  In_Ready     out  1       station can accept (= Count != DEPTH, from registered state only)
//  In_Op        in   5       ALU op
//  In_Cond      in   4       condition field
//  In_Shamt5    in   5       shift amount
//  In_Sh        in   2       shift type
//  In_ALUSrc    in   1       1: SrcB = In_ExtImm, bit1 of In_Busy ignored
//  In_ExtImm    in   DATA_W  extended immediate
//  In_RD1/RD2   in   DATA_W  register-file operand values
//  In_Busy      in   2       [0] SrcA pending, [1] SrcB pending (rename lookup)
//  In_Tag1/2    in   TAG_W   ROB tag producing SrcA/SrcB when pending
//  In_Dest      in   TAG_W   ROB tail tag of this instruction
//  CDB_Valid    in   1       result broadcast valid
//  CDB_Tag      in   TAG_W   broadcast ROB tag
//  CDB_Data     in   DATA_W  broadcast value
//  Exec_Valid   out  1       output register holds an issued instruction
//  Exec_Ready   in   1       ALU accepts
//  Exec_Op/Cond/Shamt5/Sh/ALUSrc  out  5/4/5/2/1  fields of issued instruction
//  Exec_SrcA/SrcB  out  DATA_W  resolved operands
//  Exec_Dest    out  TAG_W   ROB tag for the result
//  Count        out  $clog2(DEPTH+1)  valid entries (excludes output register)
// BEHAVIOUR
//  - Reset (Reset_n=0 at edge): all entries invalid, Exec_Valid=0, every Exec_* field=0, Count=0.
//  - Append: In_Valid & In_Ready at edge -> lowest-index free entry written. Operand pending iff Busy bit
//    set AND NOT (CDB_Valid & CDB_Tag==In_TagN) in the same cycle; on that match CDB_Data is captured (bypass).
//  - Wakeup: each valid entry with pending operand whose tag == CDB_Tag while CDB_Valid captures
//    CDB_Data and clears pending at that edge; both operands may wake in one cycle.
//  - Ready = valid & no pending operand (registered state). Select when (~Exec_Valid | Exec_Ready):
//    chosen entry moves to output register at the edge, its slot freed, Exec_Valid=1.
//  - Exec_* held stable while Exec_Valid & ~Exec_Ready. No ready entry and output consumed -> Exec_Valid=0.
//  - Latency: ready-at-append entry shows Exec_Valid after the next edge (1 cycle in station);
//    CDB-woken entry one cycle after the wakeup edge. Throughput 1 issue/cycle.
//  - Simultaneous append + issue + wakeup in one cycle all take effect; Count = Count+app-iss.
//    In_Ready does not see the same-cycle free (no Exec_Ready->In_Ready path).
//  - Full: In_Ready=0, In_Valid ignored, no state change from it.
//  - Flush (Reset_n=1): priority over append/issue; next edge all entries invalid, Exec_Valid=0,
//    Count=0; Exec_* data fields keep last value. Reset has priority over Flush.
//  - Tags compared at full TAG_W; Count never exceeds DEPTH.
// CONFIGURATION
//  RS_AGE_ORDER_EN defined: each entry keeps AGE ($clog2(DEPTH) bits) = number of older valid entries;
//   append sets AGE=Count-(issue this cycle); on issue of age a, entries with AGE>a decrement.
//   Select = ready entry with smallest AGE (oldest first).
//  RS_AGE_ORDER_EN undefined: no AGE state; select = lowest-index ready entry.
// TESTING
//  1 Reset_n=0 two edges, In_Valid=1 -> Exec_Valid=0, Count=0, In_Ready=1, no entry written.
//  2 Append Op=ADD RD1=5 RD2=7 Busy=00 Dest=2, Exec_Ready=1 -> next edge Exec_Valid=1 SrcA=5 SrcB=7 Dest=2, Count=0.
//  3 Append Busy=01 Tag1=3 RD2=9; CDB tag 4 then tag 3 data 0x1234 -> no issue on tag 4; Exec_Valid one
//    cycle after tag-3 edge with SrcA=0x1234 SrcB=9. Repeat with CDB tag 3 in append cycle -> issues as #2.
//  4 DEPTH=4, Exec_Ready=0, append 5 ready instrs -> Exec_Valid holds #0, Count=4, In_Ready=0, 6th ignored;
//    raise Exec_Ready -> #0..#4 delivered in order, one per cycle.
//  5 Append A,B,C waiting tags 1,2,3; CDB 1 -> A issues, slot0 freed; append D ready into slot0; CDB 3 ->
//    RS_AGE_ORDER_EN: C then D; undefined: D then C.
//  6 Three entries waiting + Exec_Valid held, assert Flush with In_Valid=1 -> next edge Count=0, Exec_Valid=0;
//    later CDB match issues nothing.

Source files
------------

// File: rtl/alu_reservation_station.sv
// ALU reservation station: DEPTH entries with CDB wakeup/bypass, one valid/ready issue port, 1-cycle minimum residency.
// In_Ready comes from registered occupancy only. Define RS_AGE_ORDER_EN for oldest-first selection (default: lowest index).
module alu_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [4:0]                 i_in_op,
  input  logic [3:0]                 i_in_cond,
  input  logic [4:0]                 i_in_shamt5,
  input  logic [1:0]                 i_in_sh,
  input  logic                       i_in_alusrc,
  input  logic [DATA_W-1:0]          i_in_ext_imm,
  input  logic [DATA_W-1:0]          i_in_rd1,
  input  logic [DATA_W-1:0]          i_in_rd2,
  input  logic [1:0]                 i_in_busy,
  input  logic [TAG_W-1:0]           i_in_tag1,
  input  logic [TAG_W-1:0]           i_in_tag2,
  input  logic [TAG_W-1:0]           i_in_dest,
  input  logic                       i_cdb_valid,
  input  logic [TAG_W-1:0]           i_cdb_tag,
  input  logic [DATA_W-1:0]          i_cdb_data,
  output logic                       o_exec_valid,
  input  logic                       i_exec_ready,
  output logic [4:0]                 o_exec_op,
  output logic [3:0]                 o_exec_cond,
  output logic [4:0]                 o_exec_shamt5,
  output logic [1:0]                 o_exec_sh,
  output logic                       o_exec_alusrc,
  output logic [DATA_W-1:0]          o_exec_src_a,
  output logic [DATA_W-1:0]          o_exec_src_b,
  output logic [TAG_W-1:0]           o_exec_dest,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [4:0]        op;
    logic [3:0]        cond;
    logic [4:0]        shamt5;
    logic [1:0]        sh;
    logic              alusrc;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [TAG_W-1:0]  dest;
  } uop_t;

  uop_t             r_uop [DEPTH];
  logic [TAG_W-1:0] r_tag_a [DEPTH];
  logic [TAG_W-1:0] r_tag_b [DEPTH];
  logic [DEPTH-1:0] r_vld, r_pend_a, r_pend_b;
  uop_t             r_exec;
  logic             r_exec_vld;
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0] w_rdy;
  logic             w_sel_vld, w_issue, w_append, w_in_ready;
  logic [IDX_W-1:0] w_sel_idx, w_free_idx;
  logic             w_byp_a, w_byp_b, w_new_pend_a, w_new_pend_b;
  logic [DATA_W-1:0] w_new_a, w_new_b;

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0] r_age [DEPTH];
  logic [IDX_W-1:0] w_best_age;

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_idx  = '0;
    w_best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rdy[i] && (!w_sel_vld || r_age[i] < w_best_age)) begin
        w_sel_vld  = 1'b1;
        w_sel_idx  = IDX_W'(i);
        w_best_age = r_age[i];
      end
    end
  end

  // AGE counts older valid entries; closing the gap left by the issued entry keeps ages dense.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_issue && r_vld[i] && r_age[i] > w_best_age) r_age[i] <= r_age[i] - 1'b1;
      if (w_append) r_age[w_free_idx] <= IDX_W'(r_count - CNT_W'(w_issue));
    end
  end
`else
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (w_rdy[i]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!r_vld[i]) w_free_idx = IDX_W'(i);
  end

  assign w_rdy      = r_vld & ~r_pend_a & ~r_pend_b;
  assign w_in_ready = (r_count != CNT_W'(DEPTH));
  assign w_append   = i_in_valid & w_in_ready & ~i_flush;
  assign w_issue    = w_sel_vld & (~r_exec_vld | i_exec_ready) & ~i_flush;

  // Same-cycle CDB bypass on append.
  assign w_byp_a      = i_cdb_valid && (i_cdb_tag == i_in_tag1);
  assign w_byp_b      = i_cdb_valid && (i_cdb_tag == i_in_tag2);
  assign w_new_pend_a = i_in_busy[0] & ~w_byp_a;
  assign w_new_pend_b = ~i_in_alusrc & i_in_busy[1] & ~w_byp_b;
  assign w_new_a      = (i_in_busy[0] & w_byp_a) ? i_cdb_data : i_in_rd1;
  assign w_new_b      = i_in_alusrc ? i_in_ext_imm :
                        (i_in_busy[1] & w_byp_b) ? i_cdb_data : i_in_rd2;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_vld      <= '0;
      r_exec_vld <= 1'b0;
      r_count    <= '0;
    end else if (i_flush) begin
      r_vld      <= '0;
      r_exec_vld <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_issue)  r_vld[w_sel_idx]  <= 1'b0;
      if (w_append) r_vld[w_free_idx] <= 1'b1;
      r_exec_vld <= w_issue | (r_exec_vld & ~i_exec_ready);
      r_count    <= r_count + CNT_W'(w_append) - CNT_W'(w_issue);
    end
  end

  // Payload and pending flags are only meaningful while the entry is valid, so they need no reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && r_pend_a[i] && i_cdb_valid && i_cdb_tag == r_tag_a[i]) begin
        r_pend_a[i]       <= 1'b0;
        r_uop[i].src_a    <= i_cdb_data;
      end
      if (r_vld[i] && r_pend_b[i] && i_cdb_valid && i_cdb_tag == r_tag_b[i]) begin
        r_pend_b[i]       <= 1'b0;
        r_uop[i].src_b    <= i_cdb_data;
      end
    end
    if (w_append) begin
      r_uop[w_free_idx]    <= '{op: i_in_op, cond: i_in_cond, shamt5: i_in_shamt5, sh: i_in_sh,
                                alusrc: i_in_alusrc, src_a: w_new_a, src_b: w_new_b, dest: i_in_dest};
      r_pend_a[w_free_idx] <= w_new_pend_a;
      r_pend_b[w_free_idx] <= w_new_pend_b;
      r_tag_a[w_free_idx]  <= i_in_tag1;
      r_tag_b[w_free_idx]  <= i_in_tag2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)   r_exec <= '0;
    else if (w_issue) r_exec <= r_uop[w_sel_idx];
  end

  assign o_in_ready    = w_in_ready;
  assign o_exec_valid  = r_exec_vld;
  assign o_exec_op     = r_exec.op;
  assign o_exec_cond   = r_exec.cond;
  assign o_exec_shamt5 = r_exec.shamt5;
  assign o_exec_sh     = r_exec.sh;
  assign o_exec_alusrc = r_exec.alusrc;
  assign o_exec_src_a  = r_exec.src_a;
  assign o_exec_src_b  = r_exec.src_b;
  assign o_exec_dest   = r_exec.dest;
  assign o_count       = r_count;
endmodule
